// File: rtl/udm_uart_rx.sv
`default_nettype none
// ============================================================================
// Module   : udm_uart_rx
// Purpose  : UART receive front-end for the UDM debug port. Deserializes the
//            host RX line into bytes and hands them to the command decoder
//            over a 1-entry valid/ready byte buffer. Reports framing errors,
//            overruns, and discards start-bit glitches.
// Ports    : clk_i        system clock
//            rstn_i       asynchronous active-low reset
//            rx_i         serial line, idle high
//            div_i        clocks per bit, latched at start detection (>= 4)
//            stop2_i      0: one stop bit, 1: two stop bits (latched with div_i)
//            rx_data_o    received byte
//            rx_valid_o   rx_data_o holds an unconsumed byte
//            rx_ready_i   consumer accepts byte when valid & ready
//            frame_err_o  1-cycle pulse, stop bit sampled low
//            overrun_o    1-cycle pulse, byte completed while buffer full
//            busy_o       receiver is inside a frame
// Revision : 1.0 - initial release
// ============================================================================
module udm_uart_rx #(
    parameter int unsigned DIV_W       = 32,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic             clk_i,
    input  logic             rstn_i,
    input  logic             rx_i,
    input  logic [DIV_W-1:0] div_i,
    input  logic             stop2_i,
    output logic [7:0]       rx_data_o,
    output logic             rx_valid_o,
    input  logic             rx_ready_i,
    output logic             frame_err_o,
    output logic             overrun_o,
    output logic             busy_o
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_START = 2'd1,
        S_DATA  = 2'd2,
        S_STOP  = 2'd3
    } state_t;

    state_t                 state_q,    state_d;
    logic [SYNC_STAGES-1:0] sync_q,     sync_d;
    logic [DIV_W-1:0]       cnt_q,      cnt_d;
    logic [DIV_W-1:0]       div_q,      div_d;
    logic                   stop2_q,    stop2_d;
    logic                   stop_idx_q, stop_idx_d;
    logic [2:0]             bit_q,      bit_d;
    logic [7:0]             shift_q,    shift_d;
    logic [7:0]             data_q,     data_d;
    logic                   valid_q,    valid_d;
    logic                   ferr_q,     ferr_d;
    logic                   ovr_q,      ovr_d;
    logic                   busy_q,     busy_d;
    // Start detection requires the line to have been seen high since the
    // last framing error, so a held break produces only one error.
    logic                   armed_q,    armed_d;

    logic                   w_rx_s;
    logic [DIV_W-1:0]       w_half_m1;
    logic [DIV_W-1:0]       w_div_m1;
    logic                   w_done;
    logic                   w_start_det;

    assign w_rx_s    = sync_q[SYNC_STAGES-1];
    assign w_half_m1 = (div_q >> 1) - DIV_W'(1);
    assign w_div_m1  = div_q - DIV_W'(1);

    always_comb begin
        state_d     = state_q;
        sync_d      = {sync_q[SYNC_STAGES-2:0], rx_i};
        cnt_d       = cnt_q;
        div_d       = div_q;
        stop2_d     = stop2_q;
        stop_idx_d  = stop_idx_q;
        bit_d       = bit_q;
        shift_d     = shift_q;
        data_d      = data_q;
        valid_d     = valid_q;
        ferr_d      = 1'b0;
        ovr_d       = 1'b0;
        armed_d     = w_rx_s ? 1'b1 : armed_q;
        w_done      = 1'b0;
        w_start_det = 1'b0;

        if (valid_q && rx_ready_i) begin
            valid_d = 1'b0;
        end

        case (state_q)
            S_IDLE: begin
                if (!w_rx_s && armed_q) begin
                    w_start_det = 1'b1;
                    div_d       = div_i;
                    stop2_d     = stop2_i;
                    cnt_d       = '0;
                    state_d     = S_START;
                end
            end
            S_START: begin
                if (cnt_q == w_half_m1) begin
                    cnt_d = '0;
                    bit_d = 3'd0;
                    // Line back high at mid start bit: treat as glitch.
                    state_d = w_rx_s ? S_IDLE : S_DATA;
                end else begin
                    cnt_d = cnt_q + DIV_W'(1);
                end
            end
            S_DATA: begin
                if (cnt_q == w_div_m1) begin
                    cnt_d          = '0;
                    shift_d[bit_q] = w_rx_s;
                    if (bit_q == 3'd7) begin
                        stop_idx_d = 1'b0;
                        state_d    = S_STOP;
                    end else begin
                        bit_d = bit_q + 3'd1;
                    end
                end else begin
                    cnt_d = cnt_q + DIV_W'(1);
                end
            end
            S_STOP: begin
                if (cnt_q == w_div_m1) begin
                    cnt_d = '0;
                    if (!w_rx_s) begin
                        ferr_d  = 1'b1;
                        armed_d = 1'b0;
                        state_d = S_IDLE;
                    end else if (stop2_q && !stop_idx_q) begin
                        stop_idx_d = 1'b1;
                    end else begin
                        w_done  = 1'b1;
                        state_d = S_IDLE;
                    end
                end else begin
                    cnt_d = cnt_q + DIV_W'(1);
                end
            end
            default: state_d = S_IDLE;
        endcase

        // Completed byte: load the buffer unless it is still held by the
        // consumer; a same-cycle handshake frees the slot for the new byte.
        if (w_done) begin
            if (valid_q && !rx_ready_i) begin
                ovr_d = 1'b1;
            end else begin
                data_d  = shift_q;
                valid_d = 1'b1;
            end
        end

        busy_d = (state_d != S_IDLE);
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            state_q    <= S_IDLE;
            sync_q     <= '1;
            cnt_q      <= '0;
            div_q      <= '0;
            stop2_q    <= 1'b0;
            stop_idx_q <= 1'b0;
            bit_q      <= 3'd0;
            shift_q    <= 8'h00;
            data_q     <= 8'h00;
            valid_q    <= 1'b0;
            ferr_q     <= 1'b0;
            ovr_q      <= 1'b0;
            busy_q     <= 1'b0;
            armed_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            sync_q     <= sync_d;
            cnt_q      <= cnt_d;
            div_q      <= div_d;
            stop2_q    <= stop2_d;
            stop_idx_q <= stop_idx_d;
            bit_q      <= bit_d;
            shift_q    <= shift_d;
            data_q     <= data_d;
            valid_q    <= valid_d;
            ferr_q     <= ferr_d;
            ovr_q      <= ovr_d;
            busy_q     <= busy_d;
            armed_q    <= armed_d;
        end
    end

    assign rx_data_o   = data_q;
    assign rx_valid_o  = valid_q;
    assign frame_err_o = ferr_q;
    assign overrun_o   = ovr_q;
    assign busy_o      = busy_q;

    // Divider values below 4 leave no room for a mid-bit sample.
    a_div_legal: assert property (@(posedge clk_i) disable iff (!rstn_i)
        w_start_det |-> (div_i >= DIV_W'(4)));

endmodule
`default_nettype wire

// File: tb/tb_udm_uart_rx.sv
`default_nettype none
// ============================================================================
// Module   : tb_udm_uart_rx
// Purpose  : Self-checking bench for udm_uart_rx: reset state, exact latency,
//            table of frames, overrun, glitch, break, reset mid-frame, baud
//            mismatch, and randomized frames against a byte-level model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_udm_uart_rx;

    logic        clk = 1'b0;
    logic        rstn_i;
    logic        rx_i;
    logic [31:0] div_i;
    logic        stop2_i;
    logic [7:0]  rx_data_o;
    logic        rx_valid_o;
    logic        rx_ready_i;
    logic        frame_err_o;
    logic        overrun_o;
    logic        busy_o;

    always #5 clk = ~clk;

    udm_uart_rx #(.DIV_W(32), .SYNC_STAGES(2)) dut (
        .clk_i       (clk),
        .rstn_i      (rstn_i),
        .rx_i        (rx_i),
        .div_i       (div_i),
        .stop2_i     (stop2_i),
        .rx_data_o   (rx_data_o),
        .rx_valid_o  (rx_valid_o),
        .rx_ready_i  (rx_ready_i),
        .frame_err_o (frame_err_o),
        .overrun_o   (overrun_o),
        .busy_o      (busy_o)
    );

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    // Monitor state
    logic [7:0] rcv[$];
    int   ferr_cnt, ovr_cnt, busy_cnt, valid_hi_cnt, rise_cyc;
    logic valid_prev = 1'b0;
    logic hold_prev  = 1'b0;
    logic [7:0] hold_data = 8'h00;
    bit   rnd_ready = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (rstn_i && hold_prev) begin
            check("hold_valid", {31'd0, rx_valid_o}, 32'd1);
            check("hold_data", {24'd0, rx_data_o}, {24'd0, hold_data});
        end
        if (rx_valid_o) valid_hi_cnt++;
        if (rx_valid_o && !valid_prev && rise_cyc < 0) rise_cyc = cyc;
        if (rx_valid_o && rx_ready_i) rcv.push_back(rx_data_o);
        if (frame_err_o) ferr_cnt++;
        if (overrun_o) ovr_cnt++;
        if (busy_o) busy_cnt++;
        hold_prev  = rstn_i && rx_valid_o && !rx_ready_i;
        hold_data  = rx_data_o;
        valid_prev = rx_valid_o;
    end

    task automatic clear_mon();
        rcv.delete();
        ferr_cnt = 0; ovr_cnt = 0; busy_cnt = 0; valid_hi_cnt = 0; rise_cyc = -1;
    endtask

    // Each call ends 1 ns after a rising edge, where inputs change.
    task automatic wait_clks(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
            if (rnd_ready) rx_ready_i = 1'($urandom_range(0, 1));
        end
    endtask

    task automatic send_frame(input logic [7:0] b, input int bitc, input bit two_stop, input bit bad);
        rx_i = 1'b0;
        wait_clks(bitc);
        for (int i = 0; i < 8; i++) begin
            rx_i = b[i];
            wait_clks(bitc);
        end
        rx_i = bad ? 1'b0 : 1'b1;
        wait_clks(bitc);
        if (two_stop) begin
            rx_i = 1'b1;
            wait_clks(bitc);
        end
        rx_i = 1'b1;
    endtask

    typedef struct {
        logic [7:0] data;
        int         div;
        bit         stop2;
        bit         bad;
        int         exp_bytes;
        int         exp_ferr;
    } vec_t;

    vec_t vecs[8];

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not complete, time %0t", $time);
        $fatal(1);
    end

    initial begin
        int p;
        logic [7:0] exp_q[$];
        int exp_ferr;

        vecs[0] = '{8'hA5, 16, 1'b0, 1'b0, 1, 0};
        vecs[1] = '{8'h55, 16, 1'b0, 1'b1, 0, 1};
        vecs[2] = '{8'h12, 16, 1'b0, 1'b0, 1, 0};
        vecs[3] = '{8'h7E, 16, 1'b1, 1'b0, 1, 0};
        vecs[4] = '{8'h00,  5, 1'b0, 1'b0, 1, 0};
        vecs[5] = '{8'hFF,  4, 1'b1, 1'b0, 1, 0};
        vecs[6] = '{8'h96, 23, 1'b1, 1'b1, 0, 1};
        vecs[7] = '{8'hC3,  9, 1'b0, 1'b0, 1, 0};

        rstn_i = 1'b0; rx_i = 1'b1; div_i = 32'd16; stop2_i = 1'b0; rx_ready_i = 1'b1;
        clear_mon();
        wait_clks(3);
        check("reset_data",  {24'd0, rx_data_o}, 32'h00);
        check("reset_valid", {31'd0, rx_valid_o}, 32'd0);
        check("reset_ferr",  {31'd0, frame_err_o}, 32'd0);
        check("reset_ovr",   {31'd0, overrun_o}, 32'd0);
        check("reset_busy",  {31'd0, busy_o}, 32'd0);
        rstn_i = 1'b1;
        wait_clks(5);

        // Exact latency and single-cycle valid with ready held high
        clear_mon();
        p = cyc;
        send_frame(8'hA5, 16, 1'b0, 1'b0);
        wait_clks(40);
        check("lat_rise", rise_cyc - p, 32'd155);
        check("lat_valid_cycles", valid_hi_cnt, 32'd1);
        check("lat_count", rcv.size(), 32'd1);
        if (rcv.size() > 0) check("lat_data", {24'd0, rcv[0]}, 32'hA5);

        // Table-driven frames
        foreach (vecs[k]) begin
            clear_mon();
            div_i = vecs[k].div; stop2_i = vecs[k].stop2;
            send_frame(vecs[k].data, vecs[k].div, vecs[k].stop2, vecs[k].bad);
            wait_clks(3 * vecs[k].div + 10);
            check($sformatf("vec%0d_count", k), rcv.size(), vecs[k].exp_bytes);
            if (vecs[k].exp_bytes > 0 && rcv.size() > 0)
                check($sformatf("vec%0d_data", k), {24'd0, rcv[0]}, {24'd0, vecs[k].data});
            check($sformatf("vec%0d_ferr", k), ferr_cnt, vecs[k].exp_ferr);
            check($sformatf("vec%0d_ovr", k), ovr_cnt, 32'd0);
            check($sformatf("vec%0d_busy", k), {31'd0, busy_o}, 32'd0);
        end

        // Overrun: buffer held, second byte dropped
        div_i = 32'd16; stop2_i = 1'b0; rx_ready_i = 1'b0;
        clear_mon();
        send_frame(8'h3C, 16, 1'b0, 1'b0);
        wait_clks(5);
        send_frame(8'h81, 16, 1'b0, 1'b0);
        wait_clks(40);
        check("ovr_valid", {31'd0, rx_valid_o}, 32'd1);
        check("ovr_data", {24'd0, rx_data_o}, 32'h3C);
        check("ovr_pulses", ovr_cnt, 32'd1);
        rx_ready_i = 1'b1;
        wait_clks(1);
        rx_ready_i = 1'b0;
        wait_clks(1);
        check("ovr_valid_drop", {31'd0, rx_valid_o}, 32'd0);
        wait_clks(40);
        check("ovr_count", rcv.size(), 32'd1);
        if (rcv.size() > 0) check("ovr_first", {24'd0, rcv[0]}, 32'h3C);
        check("ovr_no_second", {31'd0, rx_valid_o}, 32'd0);
        rx_ready_i = 1'b1;

        // Start-bit glitch
        clear_mon();
        rx_i = 1'b0;
        wait_clks(4);
        rx_i = 1'b1;
        wait_clks(30);
        check("glitch_busy_max", {31'd0, busy_cnt <= 10}, 32'd1);
        check("glitch_busy_seen", {31'd0, busy_cnt > 0}, 32'd1);
        check("glitch_bytes", rcv.size(), 32'd0);
        check("glitch_ferr", ferr_cnt, 32'd0);

        // Break: single error, no restart until line goes high again
        clear_mon();
        rx_i = 1'b0;
        wait_clks(30 * 16);
        check("break_ferr", ferr_cnt, 32'd1);
        check("break_idle", {31'd0, busy_o}, 32'd0);
        rx_i = 1'b1;
        wait_clks(20);
        send_frame(8'h5A, 16, 1'b0, 1'b0);
        wait_clks(60);
        check("break_after_count", rcv.size(), 32'd1);
        if (rcv.size() > 0) check("break_after_data", {24'd0, rcv[0]}, 32'h5A);
        check("break_after_ferr", ferr_cnt, 32'd1);

        // Reset during bit 4
        clear_mon();
        rx_i = 1'b0;
        wait_clks(16);
        for (int i = 0; i < 4; i++) begin
            rx_i = i[0];
            wait_clks(16);
        end
        rx_i = 1'b1;
        wait_clks(8);
        rstn_i = 1'b0;
        wait_clks(1);
        check("rst_mid_busy", {31'd0, busy_o}, 32'd0);
        wait_clks(2);
        rstn_i = 1'b1;
        wait_clks(40);
        send_frame(8'hF0, 16, 1'b0, 1'b0);
        wait_clks(60);
        check("rst_mid_count", rcv.size(), 32'd1);
        if (rcv.size() > 0) check("rst_mid_data", {24'd0, rcv[0]}, 32'hF0);
        check("rst_mid_ferr", ferr_cnt, 32'd0);
        check("rst_mid_ovr", ovr_cnt, 32'd0);

        // Host 3% fast, two stop bits, back-to-back
        clear_mon();
        div_i = 32'd868; stop2_i = 1'b1;
        send_frame(8'h11, 842, 1'b1, 1'b0);
        send_frame(8'h22, 842, 1'b1, 1'b0);
        send_frame(8'h33, 842, 1'b1, 1'b0);
        send_frame(8'hCC, 842, 1'b1, 1'b0);
        wait_clks(1000);
        check("fast_count", rcv.size(), 32'd4);
        if (rcv.size() == 4) begin
            check("fast_b0", {24'd0, rcv[0]}, 32'h11);
            check("fast_b1", {24'd0, rcv[1]}, 32'h22);
            check("fast_b2", {24'd0, rcv[2]}, 32'h33);
            check("fast_b3", {24'd0, rcv[3]}, 32'hCC);
        end
        check("fast_ferr", ferr_cnt, 32'd0);
        check("fast_ovr", ovr_cnt, 32'd0);

        // Randomized frames: model delivers every good byte in order and one
        // framing error per bad frame; random ready never delays long
        // enough for an overrun.
        clear_mon();
        exp_q.delete();
        exp_ferr = 0;
        rnd_ready = 1'b1;
        for (int n = 0; n < 20; n++) begin
            logic [7:0] b;
            int d;
            bit s2, bad;
            b   = 8'($urandom);
            d   = $urandom_range(4, 40);
            s2  = 1'($urandom_range(0, 1));
            bad = ($urandom_range(0, 4) == 0);
            div_i = d; stop2_i = s2;
            send_frame(b, d, s2, bad);
            if (bad) exp_ferr++;
            else exp_q.push_back(b);
            div_i = 32'($urandom_range(4, 60));
            wait_clks($urandom_range(1, 2 * d));
        end
        rnd_ready = 1'b0;
        rx_ready_i = 1'b1;
        wait_clks(150);
        check("rand_count", rcv.size(), exp_q.size());
        foreach (exp_q[i]) begin
            if (i < rcv.size())
                check($sformatf("rand_byte%0d", i), {24'd0, rcv[i]}, {24'd0, exp_q[i]});
        end
        check("rand_ferr", ferr_cnt, exp_ferr);
        check("rand_ovr", ovr_cnt, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
